// File: rtl/uart_tx_dev_if.sv
// CPU-side register bus shared with the timers: word address, write strobe,
// write data and combinational read data.
interface uart_tx_dev_if;
    logic [29:0] address;
    logic        WE;
    logic [31:0] dataIn;
    logic [31:0] dataOut;

    modport master (output address, output WE, output dataIn, input dataOut);
    modport slave  (input address, input WE, input dataIn, output dataOut);
endinterface

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: register file, byte FIFO, serialiser
// FSM and a level "transmitter drained" interrupt.
//
// state | meaning
// IDLE  | line high, waiting for enable && FIFO not empty
// START | start bit (0) for div_eff cycles
// DATA  | eight data bits, LSB first, div_eff cycles each
// STOP  | stop bit (1); chains straight into the next frame if data waits
module uart_tx_dev #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DIV_DEFAULT = 16'd434
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_dev_if.slave   bus,
    output logic           txd,
    output logic           IRQ
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [15:0]   div_q, div_d;
    logic          txd_q, txd_d;
    logic          irq_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          en_q, irq_en_q;
    logic [15:0]   divisor_q;

    logic wr_data, wr_status, wr_ctrl, wr_div;
    logic full, empty, busy, push, pop, bit_done;
    logic [15:0] div_eff;
    logic [3:0]  count4;
    logic        unused_bits;

    assign wr_data   = bus.WE && (bus.address[1:0] == 2'd0);
    assign wr_status = bus.WE && (bus.address[1:0] == 2'd1);
    assign wr_ctrl   = bus.WE && (bus.address[1:0] == 2'd2);
    assign wr_div    = bus.WE && (bus.address[1:0] == 2'd3);

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign busy     = (state_q != IDLE);
    assign push     = wr_data && !full;
    assign div_eff  = (divisor_q == 16'd0) ? 16'd1 : divisor_q;
    assign bit_done = (cnt_q == div_q - 16'd1);
    assign count4   = 4'(count_q);

    // The bridge decodes the base; only the register select and low data bits matter here.
    assign unused_bits = ^{bus.address[29:2], bus.dataIn[31:16]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            div_q     <= 16'd1;
            txd_q     <= 1'b1;
            irq_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            divisor_q <= DIV_DEFAULT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            txd_q   <= txd_d;
            irq_q   <= irq_en_q & empty & ~busy;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A dropped push outranks a simultaneous clear.
            if (wr_data && full)  ovf_q <= 1'b1;
            else if (wr_status)   ovf_q <= 1'b0;
            if (wr_ctrl) begin
                en_q     <= bus.dataIn[0];
                irq_en_q <= bus.dataIn[1];
            end
            if (wr_div) divisor_q <= bus.dataIn[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) mem_q[wr_ptr_q] <= bus.dataIn[7:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en_q && !empty) state_d = START;
            START:   if (bit_done) state_d = DATA;
            DATA:    if (bit_done && idx_q == 3'd7) state_d = STOP;
            STOP:    if (bit_done) state_d = (en_q && !empty) ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop     = ((state_q == IDLE) || (state_q == STOP && bit_done)) && en_q && !empty;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        div_d   = div_q;
        txd_d   = txd_q;
        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
            div_d   = div_eff;
            cnt_d   = '0;
            txd_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: txd_d = 1'b1;
                START: begin
                    if (bit_done) begin
                        cnt_d = '0;
                        idx_d = '0;
                        txd_d = shift_q[0];
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt_d = '0;
                        if (idx_q == 3'd7) begin
                            txd_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 3'd1;
                            txd_d = shift_q[idx_q + 3'd1];
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                STOP: begin
                    txd_d = 1'b1;
                    cnt_d = bit_done ? 16'd0 : cnt_q + 16'd1;
                end
                default: txd_d = 1'b1;
            endcase
        end
    end

    always_comb begin
        bus.dataOut = 32'd0;
        case (bus.address[1:0])
            2'd1:    bus.dataOut = {24'd0, count4, ovf_q, empty, full, busy};
            2'd2:    bus.dataOut = {30'd0, irq_en_q, en_q};
            2'd3:    bus.dataOut = {16'd0, divisor_q};
            default: bus.dataOut = 32'd0;
        endcase
    end

    assign txd = txd_q;
    assign IRQ = irq_q;
endmodule
